// File: rtl/ahb_sram_bridge.sv
// AHB-Lite slave bridging one AHB port to a synchronous single-port SRAM.
// Writes complete with zero wait states. Reads stall for RAM_LATENCY+1 cycles and then
// complete. Illegal transfers get a two-cycle ERROR response.
//
// Ports:
//   ahb_clock, reset       bus/RAM clock, asynchronous active-high reset
//   ahb_hsel .. ahb_hready AHB-Lite address/data phase inputs
//   ahb_hreadyout          slave ready
//   ahb_hresp              0 = OKAY, 1 = ERROR
//   ahb_hrdata             registered read data
//   ram_addr               registered RAM word address
//   ram_byteena            registered byte lane enables
//   ram_data               RAM write data (pass-through of ahb_hwdata)
//   ram_wren, ram_rden     one-cycle RAM strobes
//   ram_q                  RAM read data
module ahb_sram_bridge #(
   parameter int unsigned ADDR_BITS   = 16,
   parameter int unsigned DATA_BITS   = 32,
   parameter int unsigned RAM_LATENCY = 1,
   parameter int unsigned RAM_WORDS   = 2 ** (ADDR_BITS - $clog2(DATA_BITS / 8))
) (
   input  logic                                   ahb_clock,
   input  logic                                   reset,
   input  logic                                   ahb_hsel,
   input  logic [1:0]                             ahb_htrans,
   input  logic [2:0]                             ahb_hsize,
   input  logic [31:0]                            ahb_haddr,
   input  logic                                   ahb_hwrite,
   input  logic [DATA_BITS-1:0]                   ahb_hwdata,
   input  logic                                   ahb_hready,
   output logic                                   ahb_hreadyout,
   output logic                                   ahb_hresp,
   output logic [DATA_BITS-1:0]                   ahb_hrdata,
   output logic [ADDR_BITS-$clog2(DATA_BITS/8)-1:0] ram_addr,
   output logic [DATA_BITS/8-1:0]                 ram_byteena,
   output logic [DATA_BITS-1:0]                   ram_data,
   output logic                                   ram_wren,
   output logic                                   ram_rden,
   input  logic [DATA_BITS-1:0]                   ram_q
);

   localparam int unsigned BE = DATA_BITS / 8;
   localparam int unsigned LB = $clog2(BE);
   localparam int unsigned IW = ADDR_BITS - LB;

   typedef enum logic [2:0] {StIdle, StWrite, StRdWait, StRdDone, StErr1, StErr2} state_e;

   state_e        state_q, state_d, accept_state;
   logic [2:0]    cnt_q;
   logic          accept, take, rd_last;
   logic          size_err, align_err, range_err, xfer_err;
   logic [BE-1:0] lane_mask;
   logic [31:0]   off, nbytes;
   logic          unused_haddr;

   assign unused_haddr = ^ahb_haddr[31:ADDR_BITS];
   assign ram_data     = ahb_hwdata;

   assign accept = ahb_hsel & ahb_htrans[1] & ahb_hready;
   // hreadyout is high exactly in the states that may start a new transfer.
   assign take    = accept & ahb_hreadyout;
   assign rd_last = (cnt_q == 3'(RAM_LATENCY));

   // Address-phase decode: lane mask and legality checks.
   always_comb begin
      off       = 32'(ahb_haddr[LB-1:0]);
      nbytes    = 32'd1 << ahb_hsize;
      size_err  = ahb_hsize > 3'(LB);
      align_err = 1'b0;
      for (int unsigned i = 0; i < LB; i++) begin
         if (ahb_haddr[i] && (i < 32'(ahb_hsize))) align_err = 1'b1;
      end
      lane_mask = '0;
      for (int unsigned i = 0; i < BE; i++) begin
         lane_mask[i] = (i >= off) && (i < off + nbytes);
      end
   end

   // The range check only exists when the RAM is smaller than the decoded window.
   if (RAM_WORDS < (2 ** IW)) begin : g_range
      assign range_err = 32'(ahb_haddr[ADDR_BITS-1:LB]) >= RAM_WORDS;
   end else begin : g_full
      assign range_err = 1'b0;
   end

   assign xfer_err     = size_err | align_err | range_err;
   assign accept_state = xfer_err ? StErr1 : (ahb_hwrite ? StWrite : StRdWait);

   // State register
   always_ff @(posedge ahb_clock or posedge reset) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StWrite, StRdDone, StErr2: state_d = take ? accept_state : StIdle;
         StRdWait: if (rd_last) state_d = StRdDone;
         StErr1:   state_d = StErr2;
         default:  state_d = StIdle;
      endcase
   end

   // Output logic
   always_comb begin
      ahb_hreadyout = 1'b1;
      ahb_hresp     = 1'b0;
      ram_wren      = 1'b0;
      ram_rden      = 1'b0;
      unique case (state_q)
         StWrite:  ram_wren = 1'b1;
         StRdWait: begin
            ahb_hreadyout = 1'b0;
            ram_rden      = (cnt_q == 3'd0);
         end
         StErr1: begin
            ahb_hreadyout = 1'b0;
            ahb_hresp     = 1'b1;
         end
         StErr2:  ahb_hresp = 1'b1;
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge ahb_clock or posedge reset) begin
      if (reset) begin
         cnt_q       <= 3'd0;
         ram_addr    <= '0;
         ram_byteena <= '0;
         ahb_hrdata  <= '0;
      end else begin
         cnt_q <= (state_q == StRdWait) ? cnt_q + 3'd1 : 3'd0;
         if (take) begin
            ram_addr    <= ahb_haddr[ADDR_BITS-1:LB];
            ram_byteena <= xfer_err ? '0 : lane_mask;
         end
         if ((state_q == StRdWait) && rd_last) ahb_hrdata <= ram_q;
      end
   end

endmodule

// File: tb/tb_ahb_sram_bridge.sv
module tb_ahb_sram_bridge;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        hsel_a, hsel_b, hwrite, hready;
   logic [1:0]  htrans;
   logic [2:0]  hsize;
   logic [31:0] haddr;
   logic [63:0] hwdata;

   // DUT A: 32-bit, latency 1, 64 words
   logic        a_hro, a_hresp, a_wren, a_rden;
   logic [31:0] a_hrdata, a_ram_data, a_q;
   logic [13:0] a_ram_addr;
   logic [3:0]  a_be;
   // DUT B: 64-bit, latency 3, full window
   logic        b_hro, b_hresp, b_wren, b_rden;
   logic [63:0] b_hrdata, b_ram_data, b_q, b_p1, b_p2;
   logic [12:0] b_ram_addr;
   logic [7:0]  b_be;

   assign hready = a_hro & b_hro;

   ahb_sram_bridge #(.ADDR_BITS(16), .DATA_BITS(32), .RAM_LATENCY(1), .RAM_WORDS(64)) u_a (
      .ahb_clock(clk), .reset(rst), .ahb_hsel(hsel_a), .ahb_htrans(htrans), .ahb_hsize(hsize),
      .ahb_haddr(haddr), .ahb_hwrite(hwrite), .ahb_hwdata(hwdata[31:0]), .ahb_hready(hready),
      .ahb_hreadyout(a_hro), .ahb_hresp(a_hresp), .ahb_hrdata(a_hrdata),
      .ram_addr(a_ram_addr), .ram_byteena(a_be), .ram_data(a_ram_data), .ram_wren(a_wren),
      .ram_rden(a_rden), .ram_q(a_q)
   );

   ahb_sram_bridge #(.ADDR_BITS(16), .DATA_BITS(64), .RAM_LATENCY(3)) u_b (
      .ahb_clock(clk), .reset(rst), .ahb_hsel(hsel_b), .ahb_htrans(htrans), .ahb_hsize(hsize),
      .ahb_haddr(haddr), .ahb_hwrite(hwrite), .ahb_hwdata(hwdata), .ahb_hready(hready),
      .ahb_hreadyout(b_hro), .ahb_hresp(b_hresp), .ahb_hrdata(b_hrdata),
      .ram_addr(b_ram_addr), .ram_byteena(b_be), .ram_data(b_ram_data), .ram_wren(b_wren),
      .ram_rden(b_rden), .ram_q(b_q)
   );

   // RAM models; read data is X outside its valid cycle so mistimed captures show up.
   logic [31:0] mem_a [64];
   logic [63:0] mem_b [256];

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (a_wren && a_be[i]) mem_a[a_ram_addr[5:0]][8*i +: 8] <= a_ram_data[8*i +: 8];
      a_q <= a_rden ? mem_a[a_ram_addr[5:0]] : 32'hx;
   end

   always @(posedge clk) begin
      for (int i = 0; i < 8; i++)
         if (b_wren && b_be[i]) mem_b[b_ram_addr[7:0]][8*i +: 8] <= b_ram_data[8*i +: 8];
      b_p1 <= b_rden ? mem_b[b_ram_addr[7:0]] : 64'hx;
      b_p2 <= b_p1;
      b_q  <= b_p2;
   end

   int errors = 0;
   int checks = 0;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bus(input logic sa, input logic sb, input logic [1:0] tr, input logic [2:0] sz,
                      input logic [31:0] ad, input logic wr);
      hsel_a = sa; hsel_b = sb; htrans = tr; hsize = sz; haddr = ad; hwrite = wr;
   endtask

   task automatic idle_bus();
      bus(1'b0, 1'b0, 2'b00, 3'd0, 32'h0, 1'b0);
   endtask

   // Called in the first data-phase cycle of a read; returns in the completion cycle.
   task automatic rd_wait(input logic use_b, output int lows, output int strobes);
      lows = 0;
      strobes = 0;
      for (int k = 0; k < 12; k++) begin
         if (use_b ? b_rden : a_rden) strobes++;
         if (use_b ? b_hro : a_hro) break;
         lows++;
         cyc();
      end
   endtask

   initial begin
      int lows, strobes, n;
      for (int i = 0; i < 64; i++) mem_a[i] = 32'h0;
      for (int i = 0; i < 256; i++) mem_b[i] = 64'h0;
      idle_bus();
      hwdata = 64'h0;
      #2 rst = 1'b1;
      cyc(); cyc();
      chk("rst_hreadyout", 64'(a_hro), 64'h1);
      chk("rst_hresp", 64'(a_hresp), 64'h0);
      chk("rst_hrdata", 64'(a_hrdata), 64'h0);
      chk("rst_ram_addr", 64'(a_ram_addr), 64'h0);
      chk("rst_byteena", 64'(a_be), 64'h0);
      chk("rst_wren_rden", 64'({a_wren, a_rden}), 64'h0);
      chk("rst_b_hrdata", 64'(b_hrdata), 64'h0);
      rst = 1'b0;
      cyc();

      // Byte write 0x13, then halfword 0x16 back to back
      bus(1'b1, 1'b0, 2'b10, 3'd0, 32'h13, 1'b1);
      cyc();
      hwdata = 64'hAA00_0000;
      bus(1'b1, 1'b0, 2'b10, 3'd1, 32'h16, 1'b1);
      chk("b13_wren", 64'(a_wren), 64'h1);
      chk("b13_byteena", 64'(a_be), 64'h8);
      chk("b13_addr", 64'(a_ram_addr), 64'h4);
      cyc();
      hwdata = 64'hBBBB_CCCC;
      idle_bus();
      chk("h16_byteena", 64'(a_be), 64'hC);
      chk("h16_addr", 64'(a_ram_addr), 64'h5);
      chk("h16_hreadyout", 64'(a_hro), 64'h1);
      cyc();
      chk("wren_drop", 64'(a_wren), 64'h0);

      // Word write 0x10
      bus(1'b1, 1'b0, 2'b10, 3'd2, 32'h10, 1'b1);
      cyc();
      hwdata = 64'hDEAD_BEEF;
      idle_bus();
      chk("w10_wren", 64'(a_wren), 64'h1);
      chk("w10_addr", 64'(a_ram_addr), 64'h4);
      chk("w10_byteena", 64'(a_be), 64'hF);
      chk("w10_hreadyout", 64'(a_hro), 64'h1);
      chk("w10_ram_data", 64'(a_ram_data), 64'hDEAD_BEEF);
      cyc();
      chk("w10_wren_once", 64'(a_wren), 64'h0);

      // Read 0x10, latency 1
      bus(1'b1, 1'b0, 2'b10, 3'd2, 32'h10, 1'b0);
      cyc();
      idle_bus();
      rd_wait(1'b0, lows, strobes);
      chk("r10_waits", 64'(lows), 64'd2);
      chk("r10_rden", 64'(strobes), 64'd1);
      chk("r10_hrdata", 64'(a_hrdata), 64'hDEAD_BEEF);
      cyc();
      chk("r10_hold", 64'(a_hrdata), 64'hDEAD_BEEF);

      // Read 0x14: halfword lanes only
      bus(1'b1, 1'b0, 2'b10, 3'd2, 32'h14, 1'b0);
      cyc();
      idle_bus();
      rd_wait(1'b0, lows, strobes);
      chk("r14_hrdata", 64'(a_hrdata), 64'hBBBB_0000);
      cyc();

      // Write 0x20 then read 0x20 back to back
      bus(1'b1, 1'b0, 2'b10, 3'd2, 32'h20, 1'b1);
      cyc();
      hwdata = 64'h1234_5678;
      bus(1'b1, 1'b0, 2'b10, 3'd2, 32'h20, 1'b0);
      chk("wr20_wren", 64'(a_wren), 64'h1);
      cyc();
      idle_bus();
      chk("wr20_no_dup", 64'(a_wren), 64'h0);
      rd_wait(1'b0, lows, strobes);
      chk("rd20_waits", 64'(lows), 64'd2);
      chk("rd20_rden", 64'(strobes), 64'd1);
      chk("rd20_hrdata", 64'(a_hrdata), 64'h1234_5678);
      cyc();

      // Unaligned halfword write at 0x11
      bus(1'b1, 1'b0, 2'b10, 3'd1, 32'h11, 1'b1);
      cyc();
      idle_bus();
      chk("una_e1", 64'({a_hresp, a_hro, a_wren}), 64'b100);
      cyc();
      chk("una_e2", 64'({a_hresp, a_hro, a_wren}), 64'b110);
      cyc();
      chk("una_done", 64'({a_hresp, a_hro}), 64'b01);

      // Read beyond RAM_WORDS
      bus(1'b1, 1'b0, 2'b10, 3'd2, 32'h100, 1'b0);
      cyc();
      idle_bus();
      chk("oor_e1", 64'({a_hresp, a_hro, a_rden}), 64'b100);
      cyc();
      chk("oor_e2", 64'({a_hresp, a_hro, a_rden}), 64'b110);
      cyc();

      // Oversized transfer on the 32-bit port
      bus(1'b1, 1'b0, 2'b10, 3'd3, 32'h18, 1'b0);
      cyc();
      idle_bus();
      chk("size_e1", 64'({a_hresp, a_hro, a_rden}), 64'b100);
      cyc(); cyc();

      // hsel=0 and BUSY: OKAY, no access, address register untouched
      bus(1'b0, 1'b0, 2'b10, 3'd2, 32'h10, 1'b1);
      cyc();
      chk("nosel", 64'({a_hro, a_hresp, a_wren, a_rden}), 64'b1000);
      chk("nosel_addr", 64'(a_ram_addr), 64'h6);
      bus(1'b1, 1'b0, 2'b01, 3'd2, 32'h10, 1'b0);
      cyc();
      chk("busy", 64'({a_hro, a_hresp, a_wren, a_rden}), 64'b1000);
      idle_bus();

      // 64-bit port: byte at 0x1D, dword at 0x10, latency 3 reads
      bus(1'b0, 1'b1, 2'b10, 3'd0, 32'h1D, 1'b1);
      cyc();
      hwdata = 64'h0000_5500_0000_0000;
      idle_bus();
      chk("b1d_byteena", 64'(b_be), 64'h20);
      chk("b1d_addr", 64'(b_ram_addr), 64'h3);
      chk("b1d_wren", 64'(b_wren), 64'h1);
      cyc();
      bus(1'b0, 1'b1, 2'b10, 3'd3, 32'h10, 1'b1);
      cyc();
      hwdata = 64'h0123_4567_89AB_CDEF;
      idle_bus();
      chk("d10_byteena", 64'(b_be), 64'hFF);
      cyc();
      bus(1'b0, 1'b1, 2'b10, 3'd3, 32'h10, 1'b0);
      cyc();
      idle_bus();
      rd_wait(1'b1, lows, strobes);
      chk("bd10_waits", 64'(lows), 64'd4);
      chk("bd10_rden", 64'(strobes), 64'd1);
      chk("bd10_hrdata", b_hrdata, 64'h0123_4567_89AB_CDEF);
      cyc();
      bus(1'b0, 1'b1, 2'b10, 3'd3, 32'h18, 1'b0);
      cyc();
      idle_bus();
      rd_wait(1'b1, lows, strobes);
      chk("bd18_waits", 64'(lows), 64'd4);
      chk("bd18_hrdata", b_hrdata, 64'h0000_5500_0000_0000);
      cyc();

      // Reset in the middle of a read
      bus(1'b1, 1'b0, 2'b10, 3'd2, 32'h10, 1'b0);
      cyc();
      idle_bus();
      chk("mid_rden", 64'(a_rden), 64'h1);
      rst = 1'b1;
      #1;
      chk("mid_rst_out", 64'({a_hro, a_hresp, a_rden, a_wren}), 64'b1000);
      chk("mid_rst_hrdata", 64'(a_hrdata), 64'h0);
      chk("mid_rst_addr", 64'(a_ram_addr), 64'h0);
      cyc();
      rst = 1'b0;
      n = 0;
      for (int k = 0; k < 4; k++) begin
         cyc();
         if (a_rden || a_wren) n++;
      end
      chk("post_rst_strobes", 64'(n), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
